// File: rtl/hmmm_pkg.sv
// hmmm_pkg: shared state, opcode, instruction-class and mux-select encodings for the HMMM controller
package hmmm_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_LOADIR = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_EXEC   = 4'd3;
  localparam state_t S_MEMRD  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_WB     = 4'd6;
  localparam state_t S_IOIN   = 4'd7;
  localparam state_t S_IOOUT  = 4'd8;
  localparam state_t S_MDWAIT = 4'd9;
  localparam state_t S_HALT   = 4'd10;
  localparam logic [3:0] OP_SYS   = 4'h0;
  localparam logic [3:0] OP_SETN  = 4'h1;
  localparam logic [3:0] OP_LOADN = 4'h2;
  localparam logic [3:0] OP_STORN = 4'h3;
  localparam logic [3:0] OP_MEMR  = 4'h4;
  localparam logic [3:0] OP_ADDN  = 4'h5;
  localparam logic [3:0] OP_ADD   = 4'h6;
  localparam logic [3:0] OP_SUB   = 4'h7;
  localparam logic [3:0] OP_MUL   = 4'h8;
  localparam logic [3:0] OP_DIV   = 4'h9;
  localparam logic [3:0] OP_MOD   = 4'hA;
  localparam logic [3:0] OP_JUMPN = 4'hB;
  localparam logic [3:0] OP_JEQZN = 4'hC;
  localparam logic [3:0] OP_JNEZN = 4'hD;
  localparam logic [3:0] OP_JGTZN = 4'hE;
  localparam logic [3:0] OP_JLTZN = 4'hF;
  typedef enum logic [4:0] {
    C_HALT, C_NOP, C_READ, C_WRITE, C_JUMPR, C_SETN, C_LOADN, C_STOREN,
    C_LOADR, C_STORER, C_ADDN, C_ADD, C_SUB, C_NEG, C_MUL, C_DIV, C_MOD,
    C_JUMPN, C_CALLN, C_JEQZN, C_JNEZN, C_JGTZN, C_JLTZN, C_ILLEGAL
  } cls_t;
  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_IMM = 2'd1;
  localparam logic [1:0] PC_RX  = 2'd2;
  localparam logic [1:0] MA_PC  = 2'd0;
  localparam logic [1:0] MA_IMM = 2'd1;
  localparam logic [1:0] MA_RY  = 2'd2;
  localparam logic [1:0] B_RY   = 2'd0;
  localparam logic [1:0] B_RX   = 2'd1;
  localparam logic [1:0] B_ZERO = 2'd2;
  localparam logic [2:0] WD_ALU = 3'd0;
  localparam logic [2:0] WD_IMM = 3'd1;
  localparam logic [2:0] WD_MEM = 3'd2;
  localparam logic [2:0] WD_IO  = 3'd3;
  localparam logic [2:0] WD_MD  = 3'd4;
  localparam logic [2:0] WD_PC  = 3'd5;
  localparam logic [1:0] MD_MUL = 2'd0;
  localparam logic [1:0] MD_DIV = 2'd1;
  localparam logic [1:0] MD_MOD = 2'd2;
endpackage

// File: rtl/hmmm_decoder.sv
// hmmm_decoder: classifies an HMMM instruction word (instr in; cls, rx_zero out)
module hmmm_decoder import hmmm_pkg::*; (
  input  logic [15:0] instr,
  output cls_t        cls,
  output logic        rx_zero
);
  logic [3:0] lo;
  assign rx_zero = instr[11:8] == 4'h0;
  assign lo = instr[3:0];
  always_comb begin
    cls = C_ILLEGAL;
    case (instr[15:12])
      OP_SYS:   cls = instr[7:4] != 4'h0 ? C_ILLEGAL :
                      lo == 4'h0 ? (rx_zero ? C_HALT : C_ILLEGAL) :
                      lo == 4'h1 ? C_READ : lo == 4'h2 ? C_WRITE :
                      lo == 4'h3 ? C_JUMPR : C_ILLEGAL;
      OP_SETN:  cls = C_SETN;
      OP_LOADN: cls = C_LOADN;
      OP_STORN: cls = C_STOREN;
      OP_MEMR:  cls = lo == 4'h0 ? C_LOADR : lo == 4'h1 ? C_STORER : C_ILLEGAL;
      OP_ADDN:  cls = C_ADDN;
      OP_ADD:   cls = instr == 16'h6000 ? C_NOP : C_ADD;
      OP_SUB:   cls = instr[7:4] == 4'h0 ? C_NEG : C_SUB;
      OP_MUL:   cls = C_MUL;
      OP_DIV:   cls = C_DIV;
      OP_MOD:   cls = C_MOD;
      OP_JUMPN: cls = rx_zero ? C_JUMPN : C_CALLN;
      OP_JEQZN: cls = C_JEQZN;
      OP_JNEZN: cls = C_JNEZN;
      OP_JGTZN: cls = C_JGTZN;
      OP_JLTZN: cls = C_JLTZN;
    endcase
  end
endmodule

// File: rtl/hmmm_controller.sv
// hmmm_controller: multicycle control FSM driving every HMMM datapath enable/select from state and decoded IR
module hmmm_controller import hmmm_pkg::*; #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        rxZero,
  input  logic        rxNeg,
  output logic        irWrite,
  output logic        pcEn,
  output logic [1:0]  pcSrc,
  output logic        memRead,
  output logic        memWrite,
  output logic [1:0]  memAddrSel,
  output logic        aluCtrl,
  output logic        aluASel,
  output logic [1:0]  aluBSel,
  output logic        regWrite,
  output logic [2:0]  wdSel,
  output logic        inReq,
  input  logic        inValid,
  output logic        outValid,
  input  logic        outReady,
  output logic        mdStart,
  output logic [1:0]  mdOp,
  input  logic        mdDone,
  output logic        halted,
  output logic        fault
);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic fault_q, fault_d;
  cls_t cls;
  logic rx_zero, md, ld, st, ind, jmp, go, md_to;
  logic [2:0] wb_sel;
  hmmm_decoder u_dec (.instr(instr), .cls(cls), .rx_zero(rx_zero));
  assign md = cls inside {C_MUL, C_DIV, C_MOD};
  assign ld = cls inside {C_LOADN, C_LOADR};
  assign st = cls inside {C_STOREN, C_STORER};
  assign ind = cls inside {C_LOADR, C_STORER};
  assign jmp = cls inside {C_JUMPN, C_JUMPR, C_JEQZN, C_JNEZN, C_JGTZN, C_JLTZN};
  assign go = cls inside {C_JUMPN, C_JUMPR, C_CALLN} ||
              (cls == C_JEQZN && rxZero) || (cls == C_JNEZN && !rxZero) ||
              (cls == C_JGTZN && !rxZero && !rxNeg) || (cls == C_JLTZN && rxNeg);
  assign wb_sel = cls == C_SETN ? WD_IMM : ld ? WD_MEM : md ? WD_MD : cls == C_CALLN ? WD_PC : WD_ALU;
  assign fault = fault_q;
  always_comb begin
    state_d = state_q;
    cnt_d = 16'd0;
    fault_d = fault_q;
    md_to = 1'b0;
    irWrite = 1'b0;
    pcEn = 1'b0;
    pcSrc = PC_INC;
    memRead = 1'b0;
    memWrite = 1'b0;
    memAddrSel = MA_PC;
    aluCtrl = 1'b0;
    aluASel = 1'b0;
    aluBSel = B_RY;
    regWrite = 1'b0;
    wdSel = WD_ALU;
    inReq = 1'b0;
    outValid = 1'b0;
    mdStart = 1'b0;
    mdOp = MD_MUL;
    halted = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        state_d = S_LOADIR;
      end
      S_LOADIR: begin
        irWrite = 1'b1;
        pcEn = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        mdStart = md;
        mdOp = cls == C_DIV ? MD_DIV : cls == C_MOD ? MD_MOD : MD_MUL;
        fault_d = fault_q | cls == C_ILLEGAL;
        state_d = cls inside {C_HALT, C_ILLEGAL} ? S_HALT : cls == C_NOP ? S_FETCH :
                  cls == C_READ ? S_IOIN : cls == C_WRITE ? S_IOOUT : md ? S_MDWAIT : S_EXEC;
      end
      S_EXEC: begin
        aluCtrl = cls inside {C_SUB, C_NEG};
        aluASel = cls == C_ADDN;
        aluBSel = cls == C_NEG ? B_ZERO : cls == C_ADDN ? B_RX : B_RY;
        pcEn = go;
        pcSrc = !go ? PC_INC : cls == C_JUMPR ? PC_RX : PC_IMM;
        state_d = ld ? S_MEMRD : st ? S_MEMWR : jmp ? S_FETCH : S_WB;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        memAddrSel = ind ? MA_RY : MA_IMM;
        state_d = S_WB;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        memAddrSel = ind ? MA_RY : MA_IMM;
        state_d = S_FETCH;
      end
      S_WB: begin
        regWrite = !rx_zero;
        wdSel = wb_sel;
        state_d = S_FETCH;
      end
      S_IOIN: begin
        inReq = 1'b1;
        regWrite = inValid && !rx_zero;
        wdSel = inValid ? WD_IO : WD_ALU;
        state_d = inValid ? S_FETCH : S_IOIN;
      end
      S_IOOUT: begin
        outValid = 1'b1;
        state_d = outReady ? S_FETCH : S_IOOUT;
      end
      S_MDWAIT: begin
        cnt_d = cnt_q + 16'd1;
        md_to = MD_TIMEOUT != 0 && cnt_d == 16'(MD_TIMEOUT);
        fault_d = fault_q | (md_to && !mdDone);
        state_d = mdDone ? S_WB : md_to ? S_HALT : S_MDWAIT;
      end
      S_HALT: halted = 1'b1;
      default: begin
        fault_d = 1'b1;
        state_d = S_HALT;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q <= 16'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: doc/hmmm_controller.md
Name: hmmm_controller

Overview:
- Multicycle control FSM for the ConfusedCore HMMM processor.
- Sequences the 16-bit datapath: PC, IR, register file, ALU (add: b+a; sub: b-a), unified 256-word memory, I/O port and an external multi-cycle mul/div unit.
- Decodes the IR and drives every enable and mux select in the datapath.

Parameters:
- MD_TIMEOUT, 64, cycles allowed in MDWAIT before a fault halt. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instr  in  16  current IR contents.
- rxZero  in  1  register-file read of rX equals 0.
- rxNeg  in  1  register-file read of rX has bit 15 set.
- irWrite  out  1  load IR from memory read data.
- pcEn  out  1  PC update.
- pcSrc  out  2  next PC: 0=PC+1, 1=instr[7:0], 2=rX.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- memAddrSel  out  2  memory address: 0=PC, 1=instr[7:0], 2=rY.
- aluCtrl  out  1  0=add, 1=sub.
- aluASel  out  1  ALU a input: 0=rZ, 1=sign-extended instr[7:0].
- aluBSel  out  2  ALU b input: 0=rY, 1=rX, 2=zero.
- regWrite  out  1  write rX.
- wdSel  out  3  write data: 0=ALU, 1=sext imm, 2=memory, 3=io, 4=muldiv, 5=PC.
- inReq  out  1  request input word.
- inValid  in  1  input word present.
- outValid  out  1  output word (rX) present.
- outReady  in  1  output consumer accepts.
- mdStart  out  1  one-cycle start pulse to mul/div unit.
- mdOp  out  2  0=mul, 1=div, 2=mod.
- mdDone  in  1  mul/div result valid.
- halted  out  1  processor stopped.
- fault  out  1  illegal opcode or mul/div timeout.

Behaviour:
- States: FETCH, LOADIR, DECODE, EXEC, MEMRD, MEMWR, WB, IOIN, IOOUT, MDWAIT, HALT.
- Outputs are combinational from state and decoded instr. Any signal not listed for a state is 0.
- Reset: state<=FETCH, timeout counter<=0, halted=0, fault=0. Reset applies from any state, including a pending IO or MDWAIT.
- FETCH: memRead=1, memAddrSel=0. Next state LOADIR.
- LOADIR: irWrite=1, pcEn=1, pcSrc=0. Next state DECODE.
- DECODE: register operands latched by the datapath. Next state by class:
  - halt -> HALT.
  - nop -> FETCH.
  - read -> IOIN.
  - write -> IOOUT.
  - mul/div/mod -> MDWAIT, with mdStart pulsed in this cycle.
  - popr/pushr or any undefined encoding -> HALT with fault<=1.
  - all others -> EXEC.
- EXEC:
  - add/copy: aluBSel=0, aluASel=0, aluCtrl=0. copy is add with rZ field 0 (rZ=r0 reads 0). Next state WB.
  - sub: aluCtrl=1, aluBSel=0, aluASel=0. Next state WB.
  - neg: aluCtrl=1, aluBSel=2, aluASel=0. Next state WB.
  - addn: aluBSel=1, aluASel=1, aluCtrl=0. Next state WB.
  - setn: next state WB with wdSel=1.
  - loadn/loadr: next state MEMRD. storen/storer: next state MEMWR.
  - jumpn/jumpr: pcEn=1, pcSrc=1 or 2. Next state FETCH.
  - calln: pcEn=1, pcSrc=1. Next state WB with wdSel=5. The datapath holds the return address.
  - Conditional jumps take the branch (pcEn=1, pcSrc=1) when the condition holds:
    - jeqzn: rxZero.
    - jnezn: !rxZero.
    - jgtzn: !rxZero && !rxNeg.
    - jltzn: rxNeg.
  - Conditional jumps go to FETCH whether taken or not.
- MEMRD: memRead=1, memAddrSel=1 (loadn) or 2 (loadr). Next state WB with wdSel=2.
- MEMWR: memWrite=1, same address selects as MEMRD. Next state FETCH.
- WB: regWrite=1 unless rX==0 (writes to r0 suppressed). Next state FETCH.
- IOIN: inReq=1. Holds until inValid=1. In the cycle inValid=1: regWrite (r0 rule applies), wdSel=3, next state FETCH.
- IOOUT: outValid=1. Holds until outReady=1, then next state FETCH. Exactly one transfer per write instruction.
- MDWAIT: holds until mdDone=1, then next state WB with wdSel=4.
  - Counter increments every cycle in MDWAIT. When it reaches MD_TIMEOUT (if nonzero): next state HALT, fault<=1.
  - mdDone in the same cycle as the timeout wins.
- HALT: halted=1. Absorbing state; only reset leaves it.
- Cycle counts per instruction:
  - ALU/setn/addn: 5.
  - jumps: 4.
  - load: 6.
  - store: 5.
  - IO and mul/div: 4 + wait cycles.

Decomposition:
- hmmm_pkg holds:
  - state enum.
  - opcode field constants.
  - instruction-class enum.
  - pcSrc, memAddrSel, aluBSel and wdSel encodings.
  - mdOp encodings.
- Sub-module hmmm_decoder: combinational, instr -> instruction class plus rX==0 flag. Shared with the disassembler trace monitor.

Test Plan:
- add r3,r1,r2 with r1=3, r2=5 -> after 5 cycles, WB asserts regWrite, wdSel=0, aluCtrl=0; r3=8. Next FETCH fetches PC+1.
- sub r3,r1,r2 (3-5) and neg r4,r2 -> aluCtrl=1, aluBSel=0 then 2; results 0xFFFE and 0xFFFB.
- jeqzn r1,0x20 with rxZero=1 -> pcEn/pcSrc=1 in EXEC, PC=0x20. Same with rxZero=0 -> no pcEn in EXEC, PC stays sequential. jltzn with rxNeg=1 -> taken.
- read r5 with inValid raised after 3 cycles -> inReq held 3 cycles, single regWrite with wdSel=3. read r0 -> no regWrite.
- mul r2,r3,r4 with mdDone after 7 cycles -> one mdStart pulse, WB wdSel=4. MD_TIMEOUT=4 with no mdDone -> HALT, fault=1, halted=1.
- Reset asserted mid-MDWAIT and mid-IOOUT -> next cycle state FETCH, memRead=1, all other outputs 0. Illegal popr encoding -> HALT with fault=1.
